mmio_gpio_bank: RTL and testbench
=================================

Name: mmio_gpio_bank

Overview:
Parametrised memory-mapped GPIO peripheral on the 16-bit board bus. It provides an LED output register with atomic set, clear and toggle aliases, and synchronised switch inputs. It also keeps a sticky per-bit switch-change status with write-1-to-clear semantics, per-bit interrupt enables, and an interrupt output. Read data is registered and qualified with one-cycle latency.

Parameters:
BASE_ADDR, 23'h123450, word address of register 0; bits [3:1] must be 0 (8-word aligned window)
DATA_W, 16, bus data width
GPIO_W, 16, number of LED and switch bits; GPIO_W <= DATA_W
SYNC_STAGES, 2, switch synchroniser depth; must be >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  23 [23:1]  bus word address
data_in  input  DATA_W  bus write data
write_enable  input  1  single-cycle write strobe
read_enable  input  1  single-cycle read strobe
data_out  output  DATA_W  registered read data
read_valid  output  1  high exactly one cycle after an accepted read
switches  input  GPIO_W  asynchronous switch inputs
led  output  GPIO_W  LED register contents
irq  output  1  OR of (SW_CHG & IRQ_EN)

Behaviour:
- Decode: hit = (address[23:4] == BASE_ADDR[23:4]). The offset is address[3:1]. Strobes without hit are ignored; a read without hit gives read_valid=0.
- Register map (offset: name, access):
  - 0: LED, RW.
  - 1: LED_SET, W; led |= data_in. Reads 0.
  - 2: LED_CLR, W; led &= ~data_in. Reads 0.
  - 3: LED_TOG, W; led ^= data_in. Reads 0.
  - 4: SW, RO; synchronised switches.
  - 5: SW_CHG, R/W1C.
  - 6: IRQ_EN, RW.
  - 7: reserved, reads 0.
- Writes to RO or reserved offsets are discarded.
- Only data_in[GPIO_W-1:0] is used. Read data bits above GPIO_W are zero.
- Reset values: led=0, data_out=0, read_valid=0, irq=0, SW_CHG=0, IRQ_EN=0, synchroniser and previous-sample flops=0, warm-up counter=0.
- Write latency: a write at edge k updates the register at edge k; led reflects it after edge k.
- Read latency: read_enable and hit sampled at edge k causes data_out and read_valid=1 after edge k. data_out holds its value until the next accepted read. read_valid is low otherwise.
- Simultaneous read and write in the same cycle: the write takes effect, and data_out returns the pre-write value.
- Synchroniser: a SYNC_STAGES-deep flop chain gives sw_sync. A further flop gives sw_prev. chg = sw_sync ^ sw_prev.
- Warm-up: a counter runs from 0 to SYNC_STAGES+1 after reset and then saturates. chg is masked until saturation, so asserting switches during reset causes no spurious SW_CHG.
- SW_CHG update per bit: next = (cur & ~w1c_mask) | chg_masked. On the same-cycle collision of W1C and a new change, set wins.
- irq is combinational from registered SW_CHG and IRQ_EN; no glitch path from switches.
- Reset mid-operation: all state returns to reset values asynchronously. A pending read's read_valid is suppressed.
- Latency from a switch edge to SW: visible in SW reads after SYNC_STAGES edges; SW_CHG bit set at edge SYNC_STAGES+1.

Decomposition:
- Package gpio_bank_pkg holds:
  - typedef enum logic [2:0] reg_off_t {OFF_LED, OFF_SET, OFF_CLR, OFF_TOG, OFF_SW, OFF_CHG, OFF_IRQEN, OFF_RSVD}.
  - Localparam BUS_ADDR_W = 23.
- Sub-module sync_chain (parameters WIDTH, STAGES) holds the synchroniser flops; it is instantiated once.

Test Plan:
- LED write and alias ops:
  - Write LED=16'h00F0; SET 16'h000F; CLR 16'h0030; TOG 16'hFFFF.
  - Required: led = 00F0, 00FF, 00CF, FF30 respectively, one edge after each write.
- Readback latency:
  - Read LED at edge k.
  - Required: read_valid=1 and data_out=FF30 for exactly one cycle after k. Reading reserved offset 7 gives 0. A miss (address 23'h000000) gives read_valid=0 and data_out unchanged.
- Switch change and W1C:
  - Switches 0 then 16'h0005; IRQ_EN=16'h0004.
  - Required: SW reads 0005 after 2 edges; SW_CHG=0005 at edge 3; irq=1.
  - Write SW_CHG=0004. Required: SW_CHG=0001, irq=0.
- W1C/set collision:
  - Write SW_CHG=0001 in the same cycle bit 0 registers a new change.
  - Required: SW_CHG[0] stays 1.
- Reset behaviour:
  - Hold switches=16'hFFFF through reset, then release.
  - Required: SW_CHG stays 0 and SW reads FFFF.
  - Assert reset mid-read. Required: read_valid=0, led=0, data_out=0 immediately.
- Simultaneous read and write on LED (old value 0012, write 0034):
  - Required: data_out=0012 and led=0034 after the edge.

Source files
------------

// File: rtl/mmio_gpio_bank_pkg.sv
// rtl/mmio_gpio_bank_pkg.sv - shared types and constants for the GPIO bank
package gpio_bank_pkg;

   localparam int BUS_ADDR_W = 23;

   typedef enum logic [2:0] {
      OFF_LED   = 3'd0,
      OFF_SET   = 3'd1,
      OFF_CLR   = 3'd2,
      OFF_TOG   = 3'd3,
      OFF_SW    = 3'd4,
      OFF_CHG   = 3'd5,
      OFF_IRQEN = 3'd6,
      OFF_RSVD  = 3'd7
   } reg_off_t;

endpackage

// File: rtl/mmio_gpio_bank_if.sv
// rtl/mmio_gpio_bank_if.sv - board bus signals between host and GPIO bank
interface mmio_gpio_bank_if
   import gpio_bank_pkg::*;
#(
   parameter int DATA_W = 16
) ();

   logic [BUS_ADDR_W:1] address;
   logic [DATA_W-1:0]   data_in;
   logic                write_enable;
   logic                read_enable;
   logic [DATA_W-1:0]   data_out;
   logic                read_valid;

   modport master (
      output address, data_in, write_enable, read_enable,
      input  data_out, read_valid
   );

   modport slave (
      input  address, data_in, write_enable, read_enable,
      output data_out, read_valid
   );

endinterface

// File: rtl/mmio_gpio_bank_sync_chain.sv
// rtl/mmio_gpio_bank_sync_chain.sv - multi-flop synchroniser for asynchronous inputs
module sync_chain #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped LED/switch GPIO bank with sticky change interrupts
module mmio_gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter logic [BUS_ADDR_W:1] BASE_ADDR   = 23'h123450,
   parameter int                  DATA_W      = 16,
   parameter int                  GPIO_W      = 16,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   mmio_gpio_bank_if.slave     bus,
   input  logic [GPIO_W-1:0]   switches,
   output logic [GPIO_W-1:0]   led,
   output logic                irq
);

   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int CNT_W    = $clog2(WARM_MAX + 1);

   logic              hit;
   logic              wr;
   logic              rd;
   reg_off_t          off;
   logic [GPIO_W-1:0] wdata;

   logic [GPIO_W-1:0] irq_en;
   logic [GPIO_W-1:0] sw_sync;
   logic [GPIO_W-1:0] sw_prev;
   logic [GPIO_W-1:0] sw_chg;
   logic [GPIO_W-1:0] chg_masked;
   logic [GPIO_W-1:0] w1c_mask;
   logic [CNT_W-1:0]  warm_cnt;
   logic              warm_done;

   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] data_out_q;
   logic              read_valid_q;

   assign hit   = (bus.address[BUS_ADDR_W:4] == BASE_ADDR[BUS_ADDR_W:4]);
   assign off   = reg_off_t'(bus.address[3:1]);
   assign wr    = bus.write_enable & hit;
   assign rd    = bus.read_enable & hit;
   assign wdata = bus.data_in[GPIO_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led <= '0;
      end else if (wr) begin
         case (off)
            OFF_LED: led <= wdata;
            OFF_SET: led <= led | wdata;
            OFF_CLR: led <= led & ~wdata;
            OFF_TOG: led <= led ^ wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en <= '0;
      end else if (wr && off == OFF_IRQEN) begin
         irq_en <= wdata;
      end
   end

   sync_chain #(
      .WIDTH  (GPIO_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (switches),
      .q     (sw_sync)
   );

   // Change detection stays masked until the chain and sw_prev hold real samples,
   // so switches held during reset do not register as edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm_cnt <= '0;
         sw_prev  <= '0;
      end else begin
         sw_prev <= sw_sync;
         if (!warm_done) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
         end
      end
   end

   assign warm_done  = (warm_cnt == CNT_W'(WARM_MAX));
   assign chg_masked = warm_done ? (sw_sync ^ sw_prev) : '0;
   assign w1c_mask   = (wr && off == OFF_CHG) ? wdata : '0;

   // A new change in the same cycle as its clear keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_chg <= '0;
      end else begin
         sw_chg <= (sw_chg & ~w1c_mask) | chg_masked;
      end
   end

   assign irq = |(sw_chg & irq_en);

   always_comb begin
      rd_data = '0;
      case (off)
         OFF_LED:   rd_data[GPIO_W-1:0] = led;
         OFF_SW:    rd_data[GPIO_W-1:0] = sw_sync;
         OFF_CHG:   rd_data[GPIO_W-1:0] = sw_chg;
         OFF_IRQEN: rd_data[GPIO_W-1:0] = irq_en;
         default:   rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q   <= '0;
         read_valid_q <= 1'b0;
      end else begin
         read_valid_q <= rd;
         if (rd) begin
            data_out_q <= rd_data;
         end
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.read_valid = read_valid_q;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb/tb_mmio_gpio_bank.sv - directed table-driven bench for mmio_gpio_bank
module tb_mmio_gpio_bank;

   localparam logic [23:1] BASE = 23'h123450;

   logic        clk;
   logic        reset;
   logic [15:0] switches;
   logic [15:0] led;
   logic        irq;

   int checks;
   int errors;

   mmio_gpio_bank_if #(.DATA_W(16)) bus ();

   mmio_gpio_bank #(
      .BASE_ADDR   (BASE),
      .DATA_W      (16),
      .GPIO_W      (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .switches (switches),
      .led      (led),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [2:0]  off;
      logic [15:0] wdata;
      logic [15:0] exp_led;
      logic        exp_valid;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one bus cycle after a falling edge; return at the next falling edge.
   task automatic bus_cycle(input logic wr, input logic rd, input logic [2:0] off,
                            input logic [15:0] wd, input logic miss = 1'b0);
      bus.address      = miss ? 23'h000000 : (BASE | {20'h0, off});
      bus.data_in      = wd;
      bus.write_enable = wr;
      bus.read_enable  = rd;
      @(negedge clk);
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0]  = '{1'b1, 1'b0, 3'd0, 16'h00F0, 16'h00F0, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 3'd1, 16'h000F, 16'h00FF, 1'b0, 16'h0000};
      vecs[2]  = '{1'b1, 1'b0, 3'd2, 16'h0030, 16'h00CF, 1'b0, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 3'd3, 16'hFFFF, 16'hFF30, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'hFF30, 1'b1, 16'hFF30};
      vecs[5]  = '{1'b0, 1'b1, 3'd7, 16'h0000, 16'hFF30, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'hFF30, 1'b1, 16'h0000};
      vecs[7]  = '{1'b1, 1'b0, 3'd4, 16'h1234, 16'hFF30, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 3'd7, 16'h5555, 16'hFF30, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 3'd6, 16'h0004, 16'hFF30, 1'b0, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 3'd6, 16'h0000, 16'hFF30, 1'b1, 16'h0004};
      vecs[11] = '{1'b0, 1'b1, 3'd4, 16'h0000, 16'hFF30, 1'b1, 16'h0000};

      reset            = 1'b1;
      switches         = 16'h0000;
      bus.address      = '0;
      bus.data_in      = '0;
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_led", led, 16'h0000);
      chk("reset_valid", bus.read_valid, 1'b0);
      chk("reset_dout", bus.data_out, 16'h0000);
      chk("reset_irq", irq, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         bus_cycle(vecs[i].wr, vecs[i].rd, vecs[i].off, vecs[i].wdata);
         chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
         chk($sformatf("vec%0d_valid", i), bus.read_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_rd);
         end
      end

      // read_valid lasts one cycle; a miss leaves data_out untouched
      bus_cycle(1'b0, 1'b1, 3'd0, 16'h0000);
      chk("rd_led_valid", bus.read_valid, 1'b1);
      chk("rd_led_dout", bus.data_out, 16'hFF30);
      bus_cycle(1'b0, 1'b0, 3'd0, 16'h0000);
      chk("valid_one_cycle", bus.read_valid, 1'b0);
      chk("dout_hold", bus.data_out, 16'hFF30);
      bus_cycle(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1);
      chk("miss_valid", bus.read_valid, 1'b0);
      chk("miss_dout", bus.data_out, 16'hFF30);
      bus_cycle(1'b1, 1'b0, 3'd0, 16'hAAAA, 1'b1);
      chk("miss_write_led", led, 16'hFF30);

      // switch edge: SW visible to a read sampled at edge 3, SW_CHG/irq after edge 3
      switches = 16'h0005;
      bus_cycle(1'b0, 1'b1, 3'd4, 16'h0000);
      chk("sw_e1", bus.data_out, 16'h0000);
      chk("irq_e1", irq, 1'b0);
      bus_cycle(1'b0, 1'b1, 3'd4, 16'h0000);
      chk("sw_e2", bus.data_out, 16'h0000);
      chk("irq_e2", irq, 1'b0);
      bus_cycle(1'b0, 1'b1, 3'd4, 16'h0000);
      chk("sw_e3", bus.data_out, 16'h0005);
      chk("irq_e3", irq, 1'b1);
      bus_cycle(1'b0, 1'b1, 3'd5, 16'h0000);
      chk("chg_0005", bus.data_out, 16'h0005);
      bus_cycle(1'b1, 1'b0, 3'd5, 16'h0004);
      chk("irq_after_w1c", irq, 1'b0);
      bus_cycle(1'b0, 1'b1, 3'd5, 16'h0000);
      chk("chg_0001", bus.data_out, 16'h0001);

      // W1C of bit 0 lands on the same edge as a fresh change of bit 0
      switches = 16'h0004;
      bus_cycle(1'b0, 1'b0, 3'd0, 16'h0000);
      bus_cycle(1'b0, 1'b0, 3'd0, 16'h0000);
      bus_cycle(1'b1, 1'b0, 3'd5, 16'h0001);
      bus_cycle(1'b0, 1'b1, 3'd5, 16'h0000);
      chk("collision_set_wins", bus.data_out, 16'h0001);
      bus_cycle(1'b1, 1'b0, 3'd5, 16'h0001);
      bus_cycle(1'b0, 1'b1, 3'd5, 16'h0000);
      chk("w1c_clears", bus.data_out, 16'h0000);

      // same-cycle read and write returns the old value
      bus_cycle(1'b1, 1'b0, 3'd0, 16'h0012);
      bus_cycle(1'b1, 1'b1, 3'd0, 16'h0034);
      chk("rw_dout_old", bus.data_out, 16'h0012);
      chk("rw_led_new", led, 16'h0034);
      chk("rw_valid", bus.read_valid, 1'b1);

      // asynchronous reset while a read result is being presented
      bus.address     = BASE;
      bus.read_enable = 1'b1;
      @(posedge clk);
      #1;
      bus.read_enable = 1'b0;
      chk("pre_reset_valid", bus.read_valid, 1'b1);
      switches = 16'hFFFF;
      reset    = 1'b1;
      #1;
      chk("async_valid", bus.read_valid, 1'b0);
      chk("async_led", led, 16'h0000);
      chk("async_dout", bus.data_out, 16'h0000);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      bus_cycle(1'b0, 1'b1, 3'd5, 16'h0000);
      chk("warm_chg_zero", bus.data_out, 16'h0000);
      bus_cycle(1'b0, 1'b1, 3'd4, 16'h0000);
      chk("warm_sw_ffff", bus.data_out, 16'hFFFF);
      bus_cycle(1'b1, 1'b0, 3'd6, 16'hFFFF);
      chk("warm_irq", irq, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
